pwm_bank: RTL and testbench

Parametrised multi-channel PWM generator: a successor to the onboarding single-duty PWM peripheral, with per-channel duty, a programmable prescaler and glitch-free duty updates. It sits behind the SPI register decoder inside the `tt_um_*` top level. It is written through a simple address/data strobe and drives up to `DATA_W` output pins, typically mapped onto `uo_out` and `uio_out`.

---
 rtl/pwm_bank_pkg.sv | 13 +
 rtl/pwm_channel.sv | 61 ++++++
 rtl/pwm_bank.sv | 130 +++++++++++++
 tb/tb_pwm_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_bank_pkg.sv
// pwm_bank shared definitions
// Register map addresses and control bit positions.
package pwm_bank_pkg;

  localparam logic [3:0] ADDR_OUT_EN    = 4'h0;
  localparam logic [3:0] ADDR_PWM_MODE  = 4'h1;
  localparam logic [3:0] ADDR_PRESCALE  = 4'h2;
  localparam logic [3:0] ADDR_CTRL      = 4'h3;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'h8;

  localparam int CTRL_RUN_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// pwm_bank single channel
// Active-duty register and registered output for one PWM pin.
module pwm_channel
  import pwm_bank_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_shadow,
  input  logic [DATA_W-1:0] i_pcnt,
  input  logic              i_load,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic              i_run,
  output logic              o_pwm
);

  localparam logic [DATA_W-1:0] FULL = '1;

  logic [DATA_W-1:0] r_active;
  logic              r_pwm;
  logic              w_next;

  // active duty only changes at a period boundary or while stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '0;
    end else if (i_load) begin
      r_active <= i_shadow;
    end
  end

  // next output level, highest-priority condition first
  always_comb begin
    w_next = 1'b0;
    if (!i_en) begin
      w_next = 1'b0;
    end else if (!i_mode) begin
      w_next = 1'b1;
    end else if (!i_run) begin
      w_next = 1'b0;
    end else if (r_active == FULL) begin
      w_next = 1'b1;
    end else begin
      w_next = (i_pcnt < r_active);
    end
  end

  // registered output pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_next;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank top level
// Register file, prescaler, period counter and read mux.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_pulse
);

  logic [NUM_CH-1:0] r_out_en;
  logic [NUM_CH-1:0] r_mode;
  logic [DATA_W-1:0] r_presc;
  logic              r_run;
  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [DATA_W-1:0] r_presc_cnt;
  logic [DATA_W-1:0] r_pcnt;
  logic              r_pulse;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_tick;
  logic              w_wrap;
  logic              w_load;
  logic [DATA_W-1:0] w_rd;

  assign w_tick = r_run && (r_presc_cnt >= r_presc);
  assign w_wrap = w_tick && (r_pcnt == '1);
  assign w_load = w_wrap || !r_run;

  // register file writes; duty writes go to the shadow copy only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en <= '0;
      r_mode   <= '0;
      r_presc  <= '0;
      r_run    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_shadow[c] <= '0;
      end
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_OUT_EN:   r_out_en <= wr_data[NUM_CH-1:0];
        ADDR_PWM_MODE: r_mode   <= wr_data[NUM_CH-1:0];
        ADDR_PRESCALE: r_presc  <= wr_data;
        ADDR_CTRL:     r_run    <= wr_data[CTRL_RUN_BIT];
        default:       ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_addr == ADDR_DUTY_BASE + 4'(c)) begin
          r_shadow[c] <= wr_data;
        end
      end
    end
  end

  // prescaler and period counter, both parked at 0 while stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
      r_pcnt      <= '0;
      r_pulse     <= 1'b0;
    end else begin
      r_pulse <= w_wrap;
      if (!r_run) begin
        r_presc_cnt <= '0;
        r_pcnt      <= '0;
      end else begin
        r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
        if (w_tick) begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
    end
  end

  // read mux, unmapped addresses return 0
  always_comb begin
    w_rd = '0;
    case (rd_addr)
      ADDR_OUT_EN:   w_rd[NUM_CH-1:0] = r_out_en;
      ADDR_PWM_MODE: w_rd[NUM_CH-1:0] = r_mode;
      ADDR_PRESCALE: w_rd = r_presc;
      ADDR_CTRL:     w_rd[CTRL_RUN_BIT] = r_run;
      default:       ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_addr == ADDR_DUTY_BASE + 4'(c)) begin
        w_rd = r_shadow[c];
      end
    end
  end

  // registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_shadow (r_shadow[g]),
      .i_pcnt   (r_pcnt),
      .i_load   (w_load),
      .i_en     (r_out_en[g]),
      .i_mode   (r_mode[g]),
      .i_run    (r_run),
      .o_pwm    (pwm_out[g])
    );
  end

  assign rd_data      = r_rd_data;
  assign period_pulse = r_pulse;

endmodule

// File: tb/tb_pwm_bank.sv
// pwm_bank testbench
// Register table, PWM waveforms, duty update and reset checks.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] rd_addr = '0;
  wire  [7:0] rd_data;
  wire  [7:0] pwm_out;
  wire        pp;
  wire  [7:0] rd6;
  wire  [5:0] pwm6;
  wire        pp6;

  pwm_bank #(.NUM_CH(8), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .pwm_out(pwm_out), .period_pulse(pp)
  );

  pwm_bank #(.NUM_CH(6), .DATA_W(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd6),
    .pwm_out(pwm6), .period_pulse(pp6)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] wd;
    logic [7:0] e8;
    logic [7:0] e6;
  } vec_t;

  vec_t       tbl [10];
  logic [7:0] sb_q [$];
  logic [7:0] duty [8];
  int         checks = 0;
  int         errors = 0;
  int         hi [8];
  int         np;
  int         hi1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e,
                    input string nm);
    @(negedge clk);
    rd_addr = a;
    sb_q.push_back(e);
    @(negedge clk);
    chk(nm, rd_data, sb_q.pop_front());
  endtask

  task automatic wait_pulse(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pp && n < budget);
    if (!pp) chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input int n);
    np = 0;
    for (int c = 0; c < 8; c++) hi[c] = 0;
    repeat (n) begin
      @(negedge clk);
      np += int'(pp);
      for (int c = 0; c < 8; c++) hi[c] += int'(pwm_out[c]);
    end
  endtask

  initial begin
    tbl[0] = '{4'h0, 8'hA5, 8'hA5, 8'h25};
    tbl[1] = '{4'h1, 8'h3C, 8'h3C, 8'h3C};
    tbl[2] = '{4'h2, 8'h07, 8'h07, 8'h07};
    tbl[3] = '{4'h3, 8'hFE, 8'h00, 8'h00};
    tbl[4] = '{4'h4, 8'h55, 8'h00, 8'h00};
    tbl[5] = '{4'h7, 8'hAA, 8'h00, 8'h00};
    tbl[6] = '{4'h8, 8'h11, 8'h11, 8'h11};
    tbl[7] = '{4'hD, 8'h66, 8'h66, 8'h66};
    tbl[8] = '{4'hE, 8'h77, 8'h77, 8'h00};
    tbl[9] = '{4'hF, 8'h99, 8'h99, 8'h00};
    duty = '{8'h01, 8'h20, 8'h40, 8'h60,
             8'h80, 8'hA0, 8'hC0, 8'hFE};

    cyc(2);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pulse", pp, 0);
    chk("rst_rd", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 8'h00, $sformatf("rst_rd_%0h", a));
    end

    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].a, tbl[i].wd);
      rd(tbl[i].a, tbl[i].e8, $sformatf("tbl_rd_%0h", tbl[i].a));
      chk($sformatf("tbl_rd6_%0h", tbl[i].a), rd6, tbl[i].e6);
    end
    rd(4'h0, 8'hA5, "out_en_kept");
    chk("out_en_kept6", rd6, 8'h25);
    chk("static_hi", pwm_out, 8'h81);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_pwm", pwm_out, 0);
    chk("rst2_rd", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(4'h0, 8'h00, "rst2_out_en");
    rd(4'h8, 8'h00, "rst2_duty0");

    wr(4'h2, 8'h00);
    wr(4'h8, 8'h40);
    wr(4'h0, 8'h01);
    wr(4'h1, 8'h01);
    wr(4'h3, 8'h01);
    wait_pulse(600);
    measure(256);
    chk("basic_hi", hi[0], 64);
    chk("basic_np", np, 1);
    chk("basic_pulse_256", pp, 1);

    wr(4'h8, 8'h00);
    wait_pulse(600);
    measure(256);
    chk("duty00_hi", hi[0], 0);
    wr(4'h8, 8'hFF);
    wait_pulse(600);
    measure(256);
    chk("dutyFF_hi", hi[0], 256);
    wr(4'h3, 8'h00);
    measure(50);
    chk("stopped_hi", hi[0], 0);
    chk("stopped_np", np, 0);
    wr(4'h1, 8'h00);
    measure(50);
    chk("static_run0", hi[0], 50);
    wr(4'h3, 8'h01);
    measure(300);
    chk("static_run1", hi[0], 300);

    wr(4'h3, 8'h00);
    wr(4'h1, 8'h03);
    wr(4'h0, 8'h03);
    wr(4'h9, 8'h20);
    wr(4'h3, 8'h01);
    wait_pulse(600);
    hi1 = 0;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      hi1 += int'(pwm_out[1]);
      if (k == 10) begin
        wr_en = 1'b1;
        wr_addr = 4'h9;
        wr_data = 8'hC0;
        rd_addr = 4'h9;
        sb_q.push_back(8'h20);
      end
      if (k == 11) begin
        wr_en = 1'b0;
        chk("upd_rd_old", rd_data, sb_q.pop_front());
        sb_q.push_back(8'hC0);
      end
      if (k == 12) chk("upd_rd_new", rd_data, sb_q.pop_front());
      if (k == 256) chk("upd_pulse", pp, 1);
    end
    chk("upd_old_period", hi1, 32);
    measure(256);
    chk("upd_new_period", hi[1], 192);
    chk("upd_np", np, 1);

    wr(4'h3, 8'h00);
    wr(4'h0, 8'hFF);
    wr(4'h1, 8'hFF);
    wr(4'h2, 8'd12);
    for (int c = 0; c < 8; c++) wr(4'(8 + c), duty[c]);
    wr(4'h3, 8'h01);
    wait_pulse(4000);
    measure(3328);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("presc_hi_%0d", c), hi[c], int'(duty[c]) * 13);
    end
    chk("presc_np", np, 1);
    chk("presc_pulse", pp, 1);
    chk("dut6_pulse", pp6, 1);

    cyc(1000);
    chk("dut6_pwm", pwm6, pwm_out[5:0]);
    rst_n = 1'b0;
    #1;
    chk("rst3_pwm", pwm_out, 0);
    chk("rst3_pulse", pp, 0);
    chk("rst3_rd", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), 8'h00, $sformatf("rst3_rd_%0h", a));
    end
    measure(300);
    chk("rst3_np", np, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
